// File: rtl/xbar_pkg.sv
// Shared constants and types for the xbar_rr crossbar.
package xbar_pkg;

   localparam logic        CMD_RD            = 1'b0;
   localparam logic        CMD_WR            = 1'b1;
   localparam logic [31:0] XBAR_DECERR_RDATA = 32'hDEAD_BEEF;

   // Per-slave grant state
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/xbar_rr_arb.sv
// Per-slave round-robin arbiter with IDLE/BUSY grant FSM and rotating pointer.
// req[i] means master i requests this slave this cycle.
module xbar_rr_arb
   import xbar_pkg::*;
#(
   parameter int NM = 4,
   parameter int GW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NM-1:0] req,
   input  logic          ack,
   output logic          busy,
   output logic [GW-1:0] grant
);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic          found;
   logic [GW-1:0] pick;
   int            idx;

   // Round-robin search: first requester at ptr, ptr+1, ... mod NM
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      found = 1'b0;
      pick  = ptr_q;
      idx   = 0;
      for (int k = 0; k < NM; k++) begin
         idx = (int'(ptr_q) + k) % NM;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
   end

   // Next-state: grant on IDLE, release on ack (advance ptr) or abort (keep ptr)
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_BUSY;
               grant_d = pick;
            end
         end
         ST_BUSY: begin
            if (ack) begin
               state_d = ST_IDLE;
               ptr_d   = (int'(grant_q) == NM - 1) ? '0 : grant_q + 1'b1;
            end else if (!req[grant_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, grant and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign busy  = (state_q == ST_BUSY);
   assign grant = grant_q;

endmodule

// File: rtl/xbar_rr.sv
// NM x NS req/ack crossbar with one round-robin arbiter per slave.
// Slave select is addr[AW-1 -: SW]; read data returns the cycle after ack.
// Optional: define XBAR_DECERR_EN to ack unmapped requests with m_err and
// XBAR_DECERR_RDATA; otherwise unmapped requests stall and m_err is 0.
module xbar_rr
   import xbar_pkg::*;
#(
   parameter int NM = 4,
   parameter int NS = 4,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int SW = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NM-1:0]    m_req,
   input  logic [NM*AW-1:0] m_addr,
   input  logic [NM-1:0]    m_cmd,
   input  logic [NM*DW-1:0] m_wdata,
   output logic [NM-1:0]    m_ack,
   output logic [NM*DW-1:0] m_rdata,
   output logic [NM-1:0]    m_err,
   output logic [NS-1:0]    s_req,
   output logic [NS*AW-1:0] s_addr,
   output logic [NS-1:0]    s_cmd,
   output logic [NS*DW-1:0] s_wdata,
   input  logic [NS-1:0]    s_ack,
   input  logic [NS*DW-1:0] s_rdata
);

   localparam int GW = (NM > 1) ? $clog2(NM) : 1;

   logic [SW-1:0] tgt      [NM];
   logic [NM-1:0] req_vec  [NS];
   logic [NS-1:0] busy;
   logic [GW-1:0] grant    [NS];
   logic [NM-1:0] slv_ack;
   logic [NM-1:0] err_ack;
   logic [NM-1:0] err_rd;
   logic [NM-1:0] rd_set;
   logic [SW-1:0] rd_src_d [NM];
   logic [SW-1:0] rd_src_q [NM];
   logic [NM-1:0] rd_pend_q;
   logic [NM-1:0] rd_err_q;

   // Address decode: target slave index per master
   always_comb begin
      for (int i = 0; i < NM; i++) tgt[i] = m_addr[i*AW + AW - 1 -: SW];
   end

   // Per-slave request vectors
   always_comb begin
      req_vec = '{default: '0};
      for (int s = 0; s < NS; s++)
         for (int i = 0; i < NM; i++)
            req_vec[s][i] = m_req[i] && (tgt[i] == SW'(s));
   end

   for (genvar s = 0; s < NS; s++) begin : g_arb
      xbar_rr_arb #(.NM(NM), .GW(GW)) u_arb (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (req_vec[s]),
         .ack   (s_ack[s]),
         .busy  (busy[s]),
         .grant (grant[s])
      );
   end

   // Slave side: forward the granted master's live request, zero when idle
   always_comb begin
      s_req   = busy;
      s_addr  = '0;
      s_cmd   = '0;
      s_wdata = '0;
      for (int s = 0; s < NS; s++) begin
         if (busy[s]) begin
            s_addr[s*AW +: AW]  = m_addr[grant[s]*AW +: AW];
            s_cmd[s]            = m_cmd[grant[s]];
            s_wdata[s*DW +: DW] = m_wdata[grant[s]*DW +: DW];
         end
      end
   end

   // Master side: route slave acks back and note pending reads
   always_comb begin
      slv_ack  = '0;
      rd_set   = err_rd;
      rd_src_d = '{default: '0};
      for (int s = 0; s < NS; s++) begin
         if (busy[s] && s_ack[s]) begin
            slv_ack[grant[s]] = 1'b1;
            if (m_cmd[grant[s]] == CMD_RD) begin
               rd_set[grant[s]]   = 1'b1;
               rd_src_d[grant[s]] = SW'(s);
            end
         end
      end
   end

`ifdef XBAR_DECERR_EN
   logic [NM-1:0] mapped;
   logic [NM-1:0] err_q;

   always_comb begin
      for (int i = 0; i < NM; i++) mapped[i] = int'(tgt[i]) < NS;
   end

   // Error responder: one per master, acks an unmapped request one cycle after it appears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= '0;
      else        err_q <= ~err_q & m_req & ~mapped;
   end

   assign err_ack = err_q & m_req & ~mapped;
   assign err_rd  = err_ack & ~m_cmd;
`else
   assign err_ack = '0;
   assign err_rd  = '0;
`endif

   // Read-return bookkeeping, valid for exactly one cycle after a read ack
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: rd_src is small per-master state, so it is reset along with the flags.
      if (!rst_n) begin
         rd_pend_q <= '0;
         rd_err_q  <= '0;
         rd_src_q  <= '{default: '0};
      end else begin
         rd_pend_q <= rd_set;
         rd_err_q  <= err_rd;
         rd_src_q  <= rd_src_d;
      end
   end

   // Read data return mux
   always_comb begin
      m_rdata = '0;
      for (int i = 0; i < NM; i++) begin
         if (rd_pend_q[i]) begin
            if (rd_err_q[i]) m_rdata[i*DW +: DW] = DW'(XBAR_DECERR_RDATA);
            else             m_rdata[i*DW +: DW] = s_rdata[rd_src_q[i]*DW +: DW];
         end
      end
   end

   assign m_ack = slv_ack | err_ack;
   assign m_err = err_ack;

endmodule

// File: tb/tb_xbar_rr.sv
// Directed bench for xbar_rr: a transaction-level model checked every cycle,
// plus hand-computed expectations for the documented scenarios.
module tb_xbar_rr;
   import xbar_pkg::*;

   localparam int NM = 4, NS = 4, AW = 32, DW = 32, SW = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NM-1:0]    m_req = '0;
   logic [NM*AW-1:0] m_addr = '0;
   logic [NM-1:0]    m_cmd = '0;
   logic [NM*DW-1:0] m_wdata = '0;
   logic [NM-1:0]    m_ack;
   logic [NM*DW-1:0] m_rdata;
   logic [NM-1:0]    m_err;
   logic [NS-1:0]    s_req;
   logic [NS*AW-1:0] s_addr;
   logic [NS-1:0]    s_cmd;
   logic [NS*DW-1:0] s_wdata;
   logic [NS-1:0]    s_ack = '0;
   logic [NS*DW-1:0] s_rdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'h1234_5678, 32'hCAFE_0000};

   // Second instance with 3 slaves for decode-error behaviour
   logic [NM-1:0]    m_req3 = '0;
   logic [NM*AW-1:0] m_addr3 = '0;
   logic [NM-1:0]    m_cmd3 = '0;
   logic [NM*DW-1:0] m_wdata3 = '0;
   logic [NM-1:0]    m_ack3;
   logic [NM*DW-1:0] m_rdata3;
   logic [NM-1:0]    m_err3;
   logic [2:0]       s_req3;
   logic [3*AW-1:0]  s_addr3;
   logic [2:0]       s_cmd3;
   logic [3*DW-1:0]  s_wdata3;
   logic [2:0]       s_ack3 = '0;
   logic [3*DW-1:0]  s_rdata3 = '0;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   xbar_rr #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SW(SW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
      .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
      .s_ack(s_ack), .s_rdata(s_rdata)
   );

   xbar_rr #(.NM(NM), .NS(3), .AW(AW), .DW(DW), .SW(SW)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req3), .m_addr(m_addr3), .m_cmd(m_cmd3), .m_wdata(m_wdata3),
      .m_ack(m_ack3), .m_rdata(m_rdata3), .m_err(m_err3),
      .s_req(s_req3), .s_addr(s_addr3), .s_cmd(s_cmd3), .s_wdata(s_wdata3),
      .s_ack(s_ack3), .s_rdata(s_rdata3)
   );

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_m(input int i, input logic req, input logic [31:0] a,
                        input logic cmd, input logic [31:0] wd);
      m_req[i]            = req;
      m_addr[i*AW +: AW]  = a;
      m_cmd[i]            = cmd;
      m_wdata[i*DW +: DW] = wd;
   endtask

   // ---------------- transaction-level model ----------------
   // Per slave: who owns it (-1 = nobody) and which master is served next.
   int owner  [NS] = '{default: -1};
   int next_m [NS] = '{default: 0};
   int rd_from[NM] = '{default: -1};

   function automatic int target(input int i);
      return int'(m_addr[i*AW + AW - 1 -: SW]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NS; s++) begin owner[s] = -1; next_m[s] = 0; end
         for (int i = 0; i < NM; i++) rd_from[i] = -1;
      end else begin
         for (int i = 0; i < NM; i++) rd_from[i] = -1;
         for (int s = 0; s < NS; s++) begin
            if (owner[s] >= 0) begin
               if (s_ack[s]) begin
                  if (m_cmd[owner[s]] == CMD_RD) rd_from[owner[s]] = s;
                  next_m[s] = (owner[s] + 1) % NM;
                  owner[s]  = -1;
               end else if (!(m_req[owner[s]] && target(owner[s]) == s)) begin
                  owner[s] = -1;
               end
            end else begin
               for (int k = 0; k < NM; k++) begin
                  if (owner[s] < 0 && m_req[(next_m[s] + k) % NM] &&
                      target((next_m[s] + k) % NM) == s)
                     owner[s] = (next_m[s] + k) % NM;
               end
            end
         end
      end
   end

   // Compare process: every mid-cycle, all outputs against the model
   always @(negedge clk) begin : cmp
      logic [NS-1:0]    e_sreq, e_scmd;
      logic [NS*AW-1:0] e_saddr;
      logic [NS*DW-1:0] e_swd;
      logic [NM-1:0]    e_mack;
      logic [NM*DW-1:0] e_mrd;
      e_sreq = '0; e_scmd = '0; e_saddr = '0; e_swd = '0; e_mack = '0; e_mrd = '0;
      for (int s = 0; s < NS; s++) begin
         if (owner[s] >= 0) begin
            e_sreq[s]            = 1'b1;
            e_saddr[s*AW +: AW]  = m_addr[owner[s]*AW +: AW];
            e_scmd[s]            = m_cmd[owner[s]];
            e_swd[s*DW +: DW]    = m_wdata[owner[s]*DW +: DW];
            if (s_ack[s]) e_mack[owner[s]] = 1'b1;
         end
      end
      for (int i = 0; i < NM; i++)
         if (rd_from[i] >= 0) e_mrd[i*DW +: DW] = s_rdata[rd_from[i]*DW +: DW];
      check("model_s_req",   128'(s_req),   128'(e_sreq));
      check("model_s_addr",  128'(s_addr),  128'(e_saddr));
      check("model_s_cmd",   128'(s_cmd),   128'(e_scmd));
      check("model_s_wdata", 128'(s_wdata), 128'(e_swd));
      check("model_m_ack",   128'(m_ack),   128'(e_mack));
      check("model_m_rdata", 128'(m_rdata), 128'(e_mrd));
      check("model_m_err",   128'(m_err),   128'(0));
   end

   // ---------------- directed stimulus ----------------
   int exp_order [6] = '{0, 1, 2, 3, 0, 1};
   int pulses    [NM];
   int exp_pulse [NM] = '{2, 2, 1, 1};

   initial begin
      repeat (2) @(posedge clk);
      settle();
      check("reset_s_req",   128'(s_req),   128'(0));
      check("reset_s_addr",  128'(s_addr),  128'(0));
      check("reset_m_ack",   128'(m_ack),   128'(0));
      check("reset_m_rdata", 128'(m_rdata), 128'(0));
      cyc();
      rst_n = 1'b1;
      cyc();

      // 1: single read via slave 1
      set_m(1, 1'b1, 32'h4000_0010, CMD_RD, 32'h0);
      cyc(); settle();
      check("t1_s_req1",  128'(s_req[1]), 128'(1));
      check("t1_s_addr1", 128'(s_addr[1*AW +: AW]), 128'(32'h4000_0010));
      cyc();
      cyc(); s_ack[1] = 1'b1; settle();
      check("t1_m_ack", 128'(m_ack), 128'(4'b0010));
      cyc(); s_ack[1] = 1'b0; m_req[1] = 1'b0; settle();
      check("t1_m_rdata1", 128'(m_rdata[1*DW +: DW]), 128'(32'h1234_5678));
      cyc(); settle();
      check("t1_m_rdata1_clear", 128'(m_rdata), 128'(0));

      // 2: four masters hammer slave 2, acked every busy cycle
      for (int i = 0; i < NM; i++) begin
         set_m(i, 1'b1, 32'h8000_0000 + 32'(i * 16), CMD_WR, 32'(i));
         pulses[i] = 0;
      end
      s_ack[2] = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         cyc(); settle();
         for (int i = 0; i < NM; i++) if (m_ack[i]) pulses[i]++;
         if (c % 2 == 1)
            check($sformatf("t2_grant_c%0d", c), 128'(m_ack), 128'(4'b0001 << exp_order[(c-1)/2]));
         else
            check($sformatf("t2_gap_c%0d", c), 128'(m_ack), 128'(0));
      end
      for (int i = 0; i < NM; i++)
         check($sformatf("t2_pulses_m%0d", i), 128'(pulses[i]), 128'(exp_pulse[i]));
      cyc(); m_req = '0; s_ack[2] = 1'b0;
      cyc();

      // 3: parallel write to slave 3 and read from slave 0
      set_m(0, 1'b1, 32'hC000_0000, CMD_WR, 32'h5555_AAAA);
      set_m(3, 1'b1, 32'h0000_0004, CMD_RD, 32'h0);
      cyc(); settle();
      check("t3_s_req",    128'(s_req), 128'(4'b1001));
      check("t3_s_addr3",  128'(s_addr[3*AW +: AW]), 128'(32'hC000_0000));
      check("t3_s_wdata3", 128'(s_wdata[3*DW +: DW]), 128'(32'h5555_AAAA));
      check("t3_s_cmd",    128'(s_cmd), 128'(4'b1000));
      check("t3_s_addr0",  128'(s_addr[0 +: AW]), 128'(32'h0000_0004));
      s_ack = 4'b1001; settle();
      check("t3_m_ack", 128'(m_ack), 128'(4'b1001));
      cyc(); s_ack = '0; m_req = '0; settle();
      check("t3_m_rdata", 128'(m_rdata), 128'({32'hCAFE_0000, 96'h0}));
      cyc();

      // 4: abort keeps the pointer (slave 1 pointer sits at 2 after test 1)
      set_m(2, 1'b1, 32'h4000_0020, CMD_WR, 32'h22);
      cyc(); settle();
      check("t4_s_req1", 128'(s_req[1]), 128'(1));
      cyc(); m_req[2] = 1'b0;
      cyc(); settle();
      check("t4_abort_s_req1", 128'(s_req[1]), 128'(0));
      set_m(2, 1'b1, 32'h4000_0020, CMD_WR, 32'h22);
      set_m(3, 1'b1, 32'h4000_0030, CMD_WR, 32'h33);
      cyc(); settle();
      check("t4_regrant_m2", 128'(s_addr[1*AW +: AW]), 128'(32'h4000_0020));
      s_ack[1] = 1'b1; settle();
      check("t4_m_ack", 128'(m_ack), 128'(4'b0100));
      cyc(); s_ack[1] = 1'b0; m_req = '0;
      cyc();

      // 5: reset while slave 0 busy, pointer returns to 0
      set_m(2, 1'b1, 32'h0000_0008, CMD_WR, 32'h0);
      s_ack[0] = 1'b1;
      cyc(); settle();
      check("t5_first_ack", 128'(m_ack), 128'(4'b0100));
      cyc(); s_ack[0] = 1'b0;
      cyc(); settle();
      check("t5_busy_before_rst", 128'(s_addr[0 +: AW]), 128'(32'h0000_0008));
      rst_n = 1'b0; settle();
      check("t5_rst_s_req",   128'(s_req),   128'(0));
      check("t5_rst_s_addr",  128'(s_addr),  128'(0));
      check("t5_rst_s_wdata", 128'(s_wdata), 128'(0));
      check("t5_rst_m_ack",   128'(m_ack),   128'(0));
      cyc(); rst_n = 1'b1; m_req[2] = 1'b0;
      set_m(0, 1'b1, 32'h0000_0100, CMD_WR, 32'h0);
      set_m(3, 1'b1, 32'h0000_0300, CMD_WR, 32'h0);
      cyc(); settle();
      check("t5_m0_first", 128'(s_addr[0 +: AW]), 128'(32'h0000_0100));
      s_ack[0] = 1'b1;
      cyc(); s_ack[0] = 1'b0; m_req = '0;
      cyc();

      // 6: unmapped address on the 3-slave instance
      m_req3[1]             = 1'b1;
      m_addr3[1*AW +: AW]   = 32'hC000_0000;
      m_cmd3[1]             = CMD_RD;
      settle();
      check("t6_c0_no_ack", 128'(m_ack3), 128'(0));
`ifdef XBAR_DECERR_EN
      cyc(); settle();
      check("t6_err_ack", 128'(m_ack3), 128'(4'b0010));
      check("t6_err_flag", 128'(m_err3), 128'(4'b0010));
      cyc(); m_req3 = '0; settle();
      check("t6_err_rdata", 128'(m_rdata3[1*DW +: DW]), 128'(32'hDEAD_BEEF));
      check("t6_err_clear", 128'(m_err3), 128'(0));
`else
      for (int c = 1; c <= 20; c++) begin
         cyc(); settle();
         check($sformatf("t6_stall_ack_c%0d", c), 128'(m_ack3), 128'(0));
         check($sformatf("t6_stall_sreq_c%0d", c), 128'(s_req3), 128'(0));
      end
      check("t6_no_err", 128'(m_err3), 128'(0));
      m_req3 = '0;
`endif
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
